// File: rtl/dual_port_ram_with_conflict.sv
// dual_port_ram_with_conflict
//   True dual-port synchronous RAM. Both ports share clk and can read or write
//   any of the 2**ADDR_WIDTH words on every cycle.
//   - Write/write to the same address: a round-robin pointer chooses the
//     winner. The pointer starts at A and flips after every such conflict.
//   - Write on one port with a read of the same address on the other: the
//     reader gets the new data in the same cycle (write-through).
//   Optional build macro: CONFLICT_FLAG_EN adds a registered one-cycle
//   `conflict` pulse for each write/write collision.
//
// Ports
//   clk                      rising-edge clock for all logic
//   reset                    synchronous reset, active low
//   addr_a / addr_b          port address
//   read_a / read_b          read enable; read data appears after the edge
//   write_a / write_b        write enable
//   write_data_a / _b        write data
//   read_data_a / _b         registered read data; holds when no read occurs
//   conflict                 (CONFLICT_FLAG_EN only) write/write collision pulse
module dual_port_ram_with_conflict #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic                  read_a,
  input  logic                  write_a,
  input  logic [DATA_WIDTH-1:0] write_data_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic                  read_b,
  input  logic                  write_b,
  input  logic [DATA_WIDTH-1:0] write_data_b,
  output logic [DATA_WIDTH-1:0] read_data_a,
`ifdef CONFLICT_FLAG_EN
  output logic [DATA_WIDTH-1:0] read_data_b,
  output logic                  conflict
`else
  output logic [DATA_WIDTH-1:0] read_data_b
`endif
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // 0: A owns the next write/write conflict, 1: B owns it
  logic prio_b;

  logic                  same_addr;
  logic                  ww_conflict;
  logic                  eff_write_a;
  logic                  eff_write_b;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  do_read_a;
  logic                  do_read_b;
  logic [DATA_WIDTH-1:0] next_read_a;
  logic [DATA_WIDTH-1:0] next_read_b;

  always_comb begin
    same_addr   = (addr_a == addr_b);
    ww_conflict = write_a & write_b & same_addr;
    // The losing port's write is dropped.
    eff_write_a = write_a & ~(ww_conflict & prio_b);
    eff_write_b = write_b & ~(ww_conflict & ~prio_b);
    win_data    = prio_b ? write_data_b : write_data_a;
  end

  // A port with both read and write enabled does not read. The exception is a
  // write/write collision: a port that is also reading sees the winning word.
  always_comb begin
    do_read_a   = 1'b0;
    next_read_a = read_data_a;
    if (read_a && ww_conflict) begin
      do_read_a   = 1'b1;
      next_read_a = win_data;
    end else if (read_a && !write_a) begin
      do_read_a   = 1'b1;
      next_read_a = (write_b && same_addr) ? write_data_b : mem[addr_a];
    end
  end

  always_comb begin
    do_read_b   = 1'b0;
    next_read_b = read_data_b;
    if (read_b && ww_conflict) begin
      do_read_b   = 1'b1;
      next_read_b = win_data;
    end else if (read_b && !write_b) begin
      do_read_b   = 1'b1;
      next_read_b = (write_a && same_addr) ? write_data_a : mem[addr_b];
    end
  end

  // At most one effective write can target any single word. After arbitration
  // the two effective writes never share an address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (eff_write_a) mem[addr_a] <= write_data_a;
      if (eff_write_b) mem[addr_b] <= write_data_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      read_data_a <= '0;
      read_data_b <= '0;
      prio_b      <= 1'b0;
    end else begin
      if (do_read_a) read_data_a <= next_read_a;
      if (do_read_b) read_data_b <= next_read_b;
      if (ww_conflict) prio_b <= ~prio_b;
    end
  end

`ifdef CONFLICT_FLAG_EN
  always_ff @(posedge clk) begin
    if (!reset) conflict <= 1'b0;
    else        conflict <= ww_conflict;
  end
`endif

endmodule

// File: tb/tb_dual_port_ram_with_conflict.sv
// Directed testbench for dual_port_ram_with_conflict (default 8x16 geometry).
// Inputs are driven 1 ns after a rising edge. Outputs are sampled 1 ns after
// the following edge.
module tb_dual_port_ram_with_conflict;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] addr_a, addr_b;
  logic       read_a, read_b, write_a, write_b;
  logic [7:0] write_data_a, write_data_b;
  logic [7:0] read_data_a, read_data_b;
`ifdef CONFLICT_FLAG_EN
  logic       conflict;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dual_port_ram_with_conflict #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr_a       (addr_a),
    .read_a       (read_a),
    .write_a      (write_a),
    .write_data_a (write_data_a),
    .addr_b       (addr_b),
    .read_b       (read_b),
    .write_b      (write_b),
    .write_data_b (write_data_b),
    .read_data_a  (read_data_a),
`ifdef CONFLICT_FLAG_EN
    .read_data_b  (read_data_b),
    .conflict     (conflict)
`else
    .read_data_b  (read_data_b)
`endif
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    read_a = 0; write_a = 0; read_b = 0; write_b = 0;
    addr_a = 0; addr_b = 0; write_data_a = 0; write_data_b = 0;
  endtask

  // Apply the currently driven inputs for one edge, then return all ports to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic wr2(input logic [3:0] aa, input logic [7:0] da,
                     input logic [3:0] ab, input logic [7:0] db);
    addr_a = aa; write_a = 1; write_data_a = da;
    addr_b = ab; write_b = 1; write_data_b = db;
    step();
  endtask

  task automatic rd2(input logic [3:0] aa, input logic [3:0] ab);
    addr_a = aa; read_a = 1;
    addr_b = ab; read_b = 1;
    step();
  endtask

  initial begin
    idle();
    reset = 0;
    @(posedge clk); #1;
    check("reset_rd_a", read_data_a, 8'h00);
    check("reset_rd_b", read_data_b, 8'h00);
    reset = 1;

    rd2(4'd3, 4'd3);
    check("rd3_a", read_data_a, 8'h00);
    check("rd3_b", read_data_b, 8'h00);

    // Independent writes to different addresses
    wr2(4'd1, 8'hCA, 4'd2, 8'h35);
    rd2(4'd1, 4'd2);
    check("diff_a", read_data_a, 8'hCA);
    check("diff_b", read_data_b, 8'h35);

    // Round-robin: A wins, then B wins, then A wins
    wr2(4'd4, 8'hBC, 4'd4, 8'h43);
`ifdef CONFLICT_FLAG_EN
    check("conflict_pulse", {7'd0, conflict}, 8'h01);
`endif
    rd2(4'd4, 4'd4);
`ifdef CONFLICT_FLAG_EN
    check("conflict_clear", {7'd0, conflict}, 8'h00);
`endif
    check("ww1_a", read_data_a, 8'hBC);
    check("ww1_b", read_data_b, 8'hBC);
    wr2(4'd4, 8'h69, 4'd4, 8'h96);
    rd2(4'd4, 4'd4);
    check("ww2_a", read_data_a, 8'h96);
    check("ww2_b", read_data_b, 8'h96);
    // A non-conflicting write pair must not move the pointer.
    wr2(4'd10, 8'h01, 4'd11, 8'h02);
    wr2(4'd4, 8'h11, 4'd4, 8'h22);
    rd2(4'd4, 4'd4);
    check("ww3_a", read_data_a, 8'h11);
    check("ww3_b", read_data_b, 8'h11);

    // Write A / read B at address 5: forwarded in the same cycle
    addr_a = 4'd5; write_a = 1; write_data_a = 8'hD3;
    addr_b = 4'd5; read_b = 1;
    step();
    check("fwd_ab_b", read_data_b, 8'hD3);
    addr_a = 4'd5; read_a = 1;
    step();
    check("mem5_a", read_data_a, 8'hD3);

    // Write B / read A at address 6
    addr_b = 4'd6; write_b = 1; write_data_b = 8'h2D;
    addr_a = 4'd6; read_a = 1;
    step();
    check("fwd_ba_a", read_data_a, 8'h2D);
    rd2(4'd5, 4'd6);
    check("rd5_a", read_data_a, 8'hD3);
    check("rd6_b", read_data_b, 8'h2D);

    // Reads deasserted: outputs hold
    addr_a = 4'd1; addr_b = 4'd2;
    step();
    check("hold_a", read_data_a, 8'hD3);
    check("hold_b", read_data_b, 8'h2D);

    // Read and write on the same port: write happens, output holds
    addr_a = 4'd7; read_a = 1; write_a = 1; write_data_a = 8'h55;
    step();
    check("rw_same_hold", read_data_a, 8'hD3);
    rd2(4'd7, 4'd7);
    check("rw_same_mem_a", read_data_a, 8'h55);
    check("rw_same_mem_b", read_data_b, 8'h55);

    // Edge addresses 0 and 15
    wr2(4'd15, 8'hF0, 4'd0, 8'h0F);
    rd2(4'd0, 4'd15);
    check("addr0_a", read_data_a, 8'h0F);
    check("addr15_b", read_data_b, 8'hF0);

    // Reset during a write. The pointer currently favors B; reset returns it to A.
    reset = 0;
    addr_a = 4'd8; write_a = 1; write_data_a = 8'h77;
    step();
    check("midrst_a", read_data_a, 8'h00);
    check("midrst_b", read_data_b, 8'h00);
    reset = 1;
    rd2(4'd8, 4'd1);
    check("midrst_wr_drop", read_data_a, 8'h00);
    check("midrst_mem_clr", read_data_b, 8'h00);
    wr2(4'd9, 8'hA5, 4'd9, 8'h5A);
    rd2(4'd9, 4'd9);
    check("prio_rst_a", read_data_a, 8'hA5);
    check("prio_rst_b", read_data_b, 8'hA5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dual_port_ram_with_conflict.md
Name: dual_port_ram_with_conflict

Overview:
True dual-port synchronous RAM with two independent read/write ports, A and B, both on one clock. Same-address write/write conflicts are resolved by a round-robin arbiter. A same-address read/write pair is resolved by write-through forwarding. The block is a general-purpose shared buffer between two masters in the same clock domain.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width; depth = 2**ADDR_WIDTH (16 words)

Ports:
clk  input  1  single clock; all logic on rising edge
reset  input  1  synchronous reset, active-low (asserted when 0)
addr_a  input  ADDR_WIDTH  port A address
read_a  input  1  port A read enable
write_a  input  1  port A write enable
write_data_a  input  DATA_WIDTH  port A write data
addr_b  input  ADDR_WIDTH  port B address
read_b  input  1  port B read enable
write_b  input  1  port B write enable
write_data_b  input  DATA_WIDTH  port B write data
read_data_a  output  DATA_WIDTH  port A registered read data
read_data_b  output  DATA_WIDTH  port B registered read data

Behaviour:
- Reset (reset==0 at posedge):
  - all memory words cleared to 0
  - read_data_a and read_data_b cleared to 0
  - round-robin priority pointer set to A
  - reset overrides all port activity in that cycle; any write in that cycle is discarded
- Writes:
  - a write enable sampled at a posedge updates memory at that edge
  - the written value is visible to reads from the next cycle
- Reads:
  - 1-cycle latency: read_x high at edge N gives read_data_x = mem[addr_x] after edge N
  - when read_x is low, read_data_x holds its last value
- Same port with read_x and write_x both high:
  - the write is performed
  - read_data_x holds its value (no read)
- Different addresses: both ports operate fully independently.
- Same address, read/read: both outputs get the same stored word.
- Same address, write/write (conflict):
  - only the port holding priority writes; the other port's write is dropped silently
  - after each conflict, priority toggles (A->B->A...)
  - priority changes only on a conflict
- Same address, write on one port and read on the other:
  - the reader's read_data gets the new write data in that same edge (write-through forwarding)
  - memory is updated as well
- Same address, write/write plus a read on either port: the reader receives the winning port's data.
- Address wrap: none. Addresses are fully decoded; all 16 locations are valid.

Optional Feature:
- Macro CONFLICT_FLAG_EN.
- Defined:
  - adds output port conflict (1 bit), placed after read_data_b
  - conflict is registered and pulses high for exactly one cycle after any edge at which write_a & write_b & (addr_a==addr_b)
  - conflict resets to 0
- Undefined: the port does not exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 1 cycle, then release; read addr 3 on both ports -> read_data_a = read_data_b = 0x00 the next cycle.
- Different-address writes: A writes 0xCA to addr 1 and B writes 0x35 to addr 2 in the same cycle; then read A@1, B@2 -> 0xCA and 0x35.
- Write/write conflict with round-robin:
  - first, A=0xBC and B=0x43 to addr 4 -> readback 0xBC on both ports (A wins)
  - next, A=0x69 and B=0x96 to addr 4 -> readback 0x96 (B wins)
  - a third conflict -> A wins again
- Write A / read B at addr 5, A writes 0xD3: read_data_b = 0xD3 in the same cycle's registered output; a later read A@5 also returns 0xD3.
- Write B / read A at addr 6, B writes 0x2D: read_data_a = 0x2D; a subsequent read A@5 and B@6 returns 0xD3 and 0x2D.
- Hold/mid-op reset:
  - deassert reads -> outputs hold their values
  - assert reset during a write -> the write is discarded, outputs = 0, priority returns to A (verify with the next conflict: A wins)
